// File: rtl/coolgirl_cfg_pkg.sv
// Shared types and constants for the multicart menu-configuration controller.
// The shadow and live register sets use the same packed layout.
package coolgirl_cfg_pkg;

  localparam logic [2:0] OFF_BASE_HI  = 3'd0;
  localparam logic [2:0] OFF_BASE_LO  = 3'd1;
  localparam logic [2:0] OFF_PRG_MASK = 3'd2;
  localparam logic [2:0] OFF_CHR_MASK = 3'd3;
  localparam logic [2:0] OFF_MAPPER   = 3'd4;
  localparam logic [2:0] OFF_FLAGS    = 3'd5;
  localparam logic [2:0] OFF_RESERVED = 3'd6;
  localparam logic [2:0] OFF_CONTROL  = 3'd7;

  localparam logic [7:0] DEFAULT_COMMIT_KEY  = 8'hA5;
  localparam logic [7:0] DEFAULT_DISCARD_KEY = 8'h00;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOCKED  = 2'd2
  } cfg_state_e;

  typedef struct packed {
    logic [12:0] cpuBase;
    logic [6:0]  prgMask;
    logic [4:0]  chrMask;
    logic [4:0]  mapper;
    logic        fourScreen;
    logic [1:0]  sramPage;
    logic        sramEnabled;
    logic        mapRomOn6000;
    logic        chrWriteEnabled;
    logic        prgWriteEnabled;
    logic        lockout;
  } cfg_t;

  // Merge one $500x data byte into a register set; bits a field does not use are dropped.
  function automatic cfg_t apply_write(input cfg_t cur, input logic [2:0] off, input logic [7:0] d);
    cfg_t n;
    n = cur;
    case (off)
      OFF_BASE_HI:  n.cpuBase[12:8] = d[4:0];
      OFF_BASE_LO:  n.cpuBase[7:0]  = d;
      OFF_PRG_MASK: n.prgMask       = d[6:0];
      OFF_CHR_MASK: n.chrMask       = d[4:0];
      OFF_MAPPER: begin
        n.mapper     = d[4:0];
        n.fourScreen = d[5];
      end
      OFF_FLAGS: begin
        n.sramPage        = d[1:0];
        n.sramEnabled     = d[2];
        n.mapRomOn6000    = d[3];
        n.chrWriteEnabled = d[4];
        n.prgWriteEnabled = d[5];
        n.lockout         = d[7];
      end
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/coolgirl_cfg_commit_timer.sv
// Guard-delay down-counter for pending commits; expires on the cycle it would step 1 -> 0.
module coolgirl_cfg_commit_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [3:0] i_load_value,
  input  logic       i_enable,
  output logic       o_expire
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_count <= 4'd0;
    else if (i_load)
      r_count <= i_load_value;
    else if (i_enable && (r_count != 4'd0))
      r_count <= r_count - 4'd1;
  end

  // A load on the final cycle wins, so a re-key suppresses that cycle's expiry.
  assign o_expire = i_enable && !i_load && (r_count == 4'd1);

endmodule

// File: rtl/coolgirl_config_ctrl.sv
// Decodes $5000-$5007 writes into a shadow set and applies it atomically to the
// live mapping outputs after a keyed commit and guard delay; supports one-way lockout.
module coolgirl_config_ctrl
  import coolgirl_cfg_pkg::*;
#(
  parameter logic [3:0] COMMIT_DELAY = 4'd4,
  parameter logic [7:0] COMMIT_KEY   = DEFAULT_COMMIT_KEY,
  parameter logic [7:0] DISCARD_KEY  = DEFAULT_DISCARD_KEY
) (
  input  logic        i_m2,
  input  logic        i_reset,
  input  logic [14:0] i_cpu_addr_in,
  input  logic [7:0]  i_cpu_data_in,
  input  logic        i_cpu_rw_in,
  input  logic        i_romsel,
  output logic [12:0] o_cpu_base,
  output logic [6:0]  o_prg_mask,
  output logic [4:0]  o_chr_mask,
  output logic [4:0]  o_mapper,
  output logic        o_four_screen,
  output logic [1:0]  o_sram_page,
  output logic        o_sram_enabled,
  output logic        o_map_rom_on_6000,
  output logic        o_chr_write_enabled,
  output logic        o_prg_write_enabled,
  output logic        o_lockout,
  output logic        o_commit_busy,
  output logic        o_commit_done
);

  cfg_state_e r_state, w_stateNext;
  cfg_t       r_shadow, w_shadowNext;
  cfg_t       r_live, w_liveNext;
  logic       r_commitDone, w_doneNext;
  logic       w_timerLoad, w_timerEnable, w_expire;
  logic [3:0] w_loadValue;
  logic       w_hit, w_commitKey, w_discardKey;
  logic [2:0] w_off;

  assign w_hit = !i_cpu_rw_in && i_romsel && (i_cpu_addr_in[14:12] == 3'b101) &&
                 (i_cpu_addr_in[11:3] == 9'd0);
  assign w_off        = i_cpu_addr_in[2:0];
  assign w_commitKey  = w_hit && (w_off == OFF_CONTROL) && (i_cpu_data_in == COMMIT_KEY);
  assign w_discardKey = w_hit && (w_off == OFF_CONTROL) && (i_cpu_data_in == DISCARD_KEY);

  coolgirl_cfg_commit_timer u_timer (
    .i_clk        (i_m2),
    .i_reset      (i_reset),
    .i_load       (w_timerLoad),
    .i_load_value (w_loadValue),
    .i_enable     (w_timerEnable),
    .o_expire     (w_expire)
  );

  always_comb begin
    w_stateNext   = r_state;
    w_shadowNext  = r_shadow;
    w_liveNext    = r_live;
    w_doneNext    = 1'b0;
    w_timerLoad   = 1'b0;
    w_timerEnable = 1'b0;
    w_loadValue   = COMMIT_DELAY;
    case (r_state)
      ST_OPEN: begin
        if (w_hit && (w_off != OFF_CONTROL))
          w_shadowNext = apply_write(r_shadow, w_off, i_cpu_data_in);
        if (w_commitKey) begin
          w_stateNext = ST_PENDING;
          w_timerLoad = 1'b1;
        end else if (w_discardKey) begin
          w_shadowNext = r_live;
        end
      end
      ST_PENDING: begin
        w_timerEnable = 1'b1;
        if (w_commitKey) begin
          w_timerLoad = 1'b1;
        end else if (w_discardKey) begin
          w_shadowNext = r_live;
          w_stateNext  = ST_OPEN;
          w_timerLoad  = 1'b1;
          w_loadValue  = 4'd0;
        end else if (w_expire) begin
          w_liveNext  = r_shadow;
          w_doneNext  = 1'b1;
          w_stateNext = r_shadow.lockout ? ST_LOCKED : ST_OPEN;
        end
      end
      ST_LOCKED: ;
      default: w_stateNext = ST_OPEN;
    endcase
  end

  always_ff @(posedge i_m2) begin
    if (i_reset) begin
      r_state      <= ST_OPEN;
      r_shadow     <= '0;
      r_live       <= '0;
      r_commitDone <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_shadow     <= w_shadowNext;
      r_live       <= w_liveNext;
      r_commitDone <= w_doneNext;
    end
  end

  assign o_cpu_base          = r_live.cpuBase;
  assign o_prg_mask          = r_live.prgMask;
  assign o_chr_mask          = r_live.chrMask;
  assign o_mapper            = r_live.mapper;
  assign o_four_screen       = r_live.fourScreen;
  assign o_sram_page         = r_live.sramPage;
  assign o_sram_enabled      = r_live.sramEnabled;
  assign o_map_rom_on_6000   = r_live.mapRomOn6000;
  assign o_chr_write_enabled = r_live.chrWriteEnabled;
  assign o_prg_write_enabled = r_live.prgWriteEnabled;
  assign o_lockout           = r_live.lockout;
  assign o_commit_busy       = (r_state == ST_PENDING);
  assign o_commit_done       = r_commitDone;

endmodule
